// File: rtl/data_ram_be.sv
// data_ram_be: single-port data memory for the load/store path.
// Per-byte write enables, a valid/ready request port, 1- or 2-cycle read
// latency, and a post-reset clear sequence that zeroes every word before
// any request is accepted.
module data_ram_be #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int READ_LAT   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    busy
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [ADDR_WIDTH-1:0]   clr_cnt_r;
    logic [ADDR_WIDTH-1:0]   clr_cnt_s;
    logic                    ready_r;
    logic                    busy_r;
    logic                    clr_last_s;
    logic                    accept_s;
    logic                    wr_s;
    logic                    rd_s;
    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];
    logic                    rd_valid1_r;
    logic [DATA_WIDTH-1:0]   rd_data1_r;

    // Request decode: a request is taken only while the block advertises ready.
    always_comb begin
        accept_s   = req_valid & ready_r;
        wr_s       = accept_s & req_we;
        rd_s       = accept_s & ~req_we;
        clr_last_s = (clr_cnt_r == {ADDR_WIDTH{1'b1}});
    end

    // Next-state logic: walk every word once in CLEAR, then stay in IDLE.
    always_comb begin
        state_s   = state_r;
        clr_cnt_s = clr_cnt_r;
        case (state_r)
            CLEAR: begin
                clr_cnt_s = clr_cnt_r + ADDR_WIDTH'(1);
                if (clr_last_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = CLEAR;
                end
            end
            IDLE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = CLEAR;
            end
        endcase
    end

    // State register; ready/busy are registered copies of the next state so
    // they change on the same edge the FSM does.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= CLEAR;
            clr_cnt_r <= '0;
            ready_r   <= 1'b0;
            busy_r    <= 1'b1;
        end else begin
            state_r   <= state_s;
            clr_cnt_r <= clr_cnt_s;
            ready_r   <= (state_s == IDLE);
            busy_r    <= (state_s == CLEAR);
        end
    end

    // Array write port: clear walker in CLEAR, byte-masked writes in IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_r == CLEAR) begin
                mem_r[clr_cnt_r] <= '0;
            end else if (wr_s) begin
                for (int i = 0; i < NUM_BYTES; i++) begin
                    if (req_be[i]) begin
                        mem_r[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    // First read stage: the array is sampled at the accepting edge, after any
    // write from the previous cycle has already landed. Data holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid1_r <= 1'b0;
            rd_data1_r  <= '0;
        end else begin
            rd_valid1_r <= rd_s;
            if (rd_s) begin
                rd_data1_r <= mem_r[req_addr];
            end
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic                  rd_valid2_r;
            logic [DATA_WIDTH-1:0] rd_data2_r;

            // Optional output register: adds one cycle, still holds the last value.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_valid2_r <= 1'b0;
                    rd_data2_r  <= '0;
                end else begin
                    rd_valid2_r <= rd_valid1_r;
                    if (rd_valid1_r) begin
                        rd_data2_r <= rd_data1_r;
                    end
                end
            end

            assign rsp_valid = rd_valid2_r;
            assign rsp_rdata = rd_data2_r;
        end else begin : g_lat1
            assign rsp_valid = rd_valid1_r;
            assign rsp_rdata = rd_data1_r;
        end
    endgenerate

    assign req_ready = ready_r;
    assign busy      = busy_r;

endmodule
